// File: rtl/if_fetch_pkg.sv
// Shared constants and FSM encoding for the simplemips instruction-fetch stage.
package if_fetch_pkg;

  localparam logic        RstEnable     = 1'b1;
  localparam logic [31:0] ZeroWord      = 32'h0000_0000;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  typedef enum logic [0:0] {
    StFetch = 1'b0,
    StFull  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake, holds the IF/ID register
// and applies branch redirects after one delay slot.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_addr_i,
  input  logic        next_delay_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        in_delay_o
);

  localparam logic [31:0] WordMask = 32'hFFFF_FFFC;

  fetch_state_e state_q, state_d;

  logic [31:0] fetch_pc_q;
  logic        redirect_pending_q;
  logic [31:0] redirect_target_q;
  logic        delay_flag_q;

  logic [31:0] pc_q, inst_q;
  logic        inst_valid_q, in_delay_q;

  logic fetch_ack;
  logic consume;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (fetch_ack) state_d = StFull;
      StFull:  if (consume)   state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Output / handshake decode; rst gates the request so it drops asynchronously.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = ZeroWord;
    fetch_ack   = 1'b0;
    consume     = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req_o  = (rst != RstEnable);
        imem_addr_o = imem_req_o ? fetch_pc_q : ZeroWord;
        fetch_ack   = imem_req_o & imem_ack_i;
      end
      StFull: begin
        consume = ~stall_i;
      end
      default: ;
    endcase
  end

  // PC, redirect bookkeeping and IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      fetch_pc_q         <= RESET_PC & WordMask;
      redirect_pending_q <= 1'b0;
      redirect_target_q  <= ZeroWord;
      delay_flag_q       <= 1'b0;
      pc_q               <= ZeroWord;
      inst_q             <= ZeroWord;
      inst_valid_q       <= 1'b0;
      in_delay_q         <= 1'b0;
    end else begin
      if (fetch_ack) begin
        inst_q       <= imem_data_i;
        pc_q         <= fetch_pc_q;
        in_delay_q   <= delay_flag_q;
        inst_valid_q <= 1'b1;
        // The delay-slot fetch is the one that applies a pending redirect.
        if (redirect_pending_q) begin
          fetch_pc_q         <= redirect_target_q;
          redirect_pending_q <= 1'b0;
        end else begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
      end
      if (consume) begin
        inst_valid_q <= 1'b0;
        delay_flag_q <= next_delay_i;
        if (branch_flag_i) begin
          redirect_pending_q <= 1'b1;
          redirect_target_q  <= branch_addr_i & WordMask;
        end
      end
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign in_delay_o   = in_delay_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: the bench plays instruction memory and decode stage.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b1;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        next_delay_i = 1'b0;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        in_delay_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .branch_flag_i(branch_flag_i),
    .branch_addr_i(branch_addr_i),
    .next_delay_i (next_delay_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .in_delay_o   (in_delay_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect a request at addr, ack after lat wait cycles, then check the IF/ID register.
  task automatic serve(input string tag, input int lat, input logic [31:0] addr,
                       input logic [31:0] data, input logic dly);
    check({tag, " req"}, {31'd0, imem_req_o}, 32'd1);
    check({tag, " addr"}, imem_addr_o, addr);
    for (int i = 0; i < lat; i++) begin
      step();
      check({tag, " wait req"}, {31'd0, imem_req_o}, 32'd1);
      check({tag, " wait addr"}, imem_addr_o, addr);
    end
    imem_ack_i  = 1'b1;
    imem_data_i = data;
    step();
    imem_ack_i  = 1'b0;
    imem_data_i = '0;
    check({tag, " valid"}, {31'd0, inst_valid_o}, 32'd1);
    check({tag, " pc"}, pc_o, addr);
    check({tag, " inst"}, inst_o, data);
    check({tag, " in_delay"}, {31'd0, in_delay_o}, {31'd0, dly});
    check({tag, " req low"}, {31'd0, imem_req_o}, 32'd0);
  endtask

  task automatic consume(input logic bf, input logic [31:0] ba, input logic nd);
    stall_i       = 1'b0;
    branch_flag_i = bf;
    branch_addr_i = ba;
    next_delay_i  = nd;
    step();
    stall_i       = 1'b1;
    branch_flag_i = 1'b0;
    branch_addr_i = '0;
    next_delay_i  = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst req", {31'd0, imem_req_o}, 32'd0);
    check("rst addr", imem_addr_o, 32'd0);
    check("rst valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst pc", pc_o, 32'd0);
    check("rst inst", inst_o, 32'd0);
    check("rst in_delay", {31'd0, in_delay_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Zero-wait memory, no stall: requests two cycles apart
    t0 = cyc;
    serve("zw0", 0, 32'h0000_0000, 32'h3401_0001, 1'b0);
    consume(1'b0, 32'd0, 1'b0);
    check("zw valid cleared", {31'd0, inst_valid_o}, 32'd0);
    check("zw req spacing", cyc - t0, 32'd2);

    // 3-cycle latency, then 4 stalled cycles holding the output
    serve("lat3", 3, 32'h0000_0004, 32'hAAAA_0004, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall pc hold", pc_o, 32'h0000_0004);
      check("stall inst hold", inst_o, 32'hAAAA_0004);
      check("stall valid hold", {31'd0, inst_valid_o}, 32'd1);
      check("stall no req", {31'd0, imem_req_o}, 32'd0);
    end
    consume(1'b0, 32'd0, 1'b0);

    // Taken branch at 0x10 to 0x40 with one delay slot
    serve("s8", 0, 32'h0000_0008, 32'h1111_0008, 1'b0);
    consume(1'b0, 32'd0, 1'b0);
    serve("sC", 1, 32'h0000_000C, 32'h1111_000C, 1'b0);
    consume(1'b0, 32'd0, 1'b0);
    serve("br10", 0, 32'h0000_0010, 32'h1000_000B, 1'b0);
    consume(1'b1, 32'h0000_0040, 1'b1);
    serve("ds14", 0, 32'h0000_0014, 32'h1111_0014, 1'b1);
    consume(1'b0, 32'd0, 1'b0);
    serve("tgt40", 2, 32'h0000_0040, 32'h1111_0040, 1'b0);

    // Branch from 0x40 to 0x20, then a not-taken branch at 0x20
    consume(1'b1, 32'h0000_0020, 1'b1);
    serve("ds44", 0, 32'h0000_0044, 32'h1111_0044, 1'b1);
    consume(1'b0, 32'd0, 1'b0);
    serve("nt20", 0, 32'h0000_0020, 32'h1400_0020, 1'b0);
    consume(1'b0, 32'h0000_0080, 1'b1);
    serve("ds24", 0, 32'h0000_0024, 32'h1111_0024, 1'b1);
    consume(1'b0, 32'd0, 1'b0);
    serve("nt28", 0, 32'h0000_0028, 32'h1111_0028, 1'b0);

    // Misaligned target 0x43 fetches 0x40
    consume(1'b1, 32'h0000_0043, 1'b1);
    serve("ds2C", 0, 32'h0000_002C, 32'h1111_002C, 1'b1);
    consume(1'b0, 32'd0, 1'b0);
    serve("mis40", 0, 32'h0000_0040, 32'h2222_0040, 1'b0);

    // Target at top of memory wraps to 0
    consume(1'b1, 32'hFFFF_FFFC, 1'b1);
    serve("ds44b", 0, 32'h0000_0044, 32'h2222_0044, 1'b1);
    consume(1'b0, 32'd0, 1'b0);
    serve("top", 0, 32'hFFFF_FFFC, 32'h3333_FFFC, 1'b0);
    consume(1'b0, 32'd0, 1'b0);
    serve("wrap0", 0, 32'h0000_0000, 32'h3333_0000, 1'b0);
    consume(1'b0, 32'd0, 1'b0);

    // Reset while the request at 0x8 is outstanding
    serve("pre4", 0, 32'h0000_0004, 32'h4444_0004, 1'b0);
    consume(1'b0, 32'd0, 1'b0);
    step();
    check("out req", {31'd0, imem_req_o}, 32'd1);
    check("out addr", imem_addr_o, 32'h0000_0008);
    rst = 1'b1;
    #1;
    check("mid rst req", {31'd0, imem_req_o}, 32'd0);
    check("mid rst addr", imem_addr_o, 32'd0);
    check("mid rst valid", {31'd0, inst_valid_o}, 32'd0);
    check("mid rst pc", pc_o, 32'd0);
    check("mid rst inst", inst_o, 32'd0);
    step();
    rst = 1'b0;
    #1;
    serve("post rst", 0, 32'h0000_0000, 32'h5555_0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
